mmio_result_printer: RTL and testbench

Memory-mapped result peripheral on the CPU data bus, downstream of the `cpu` core. It converts program results into an ASCII character stream. A write to the integer port emits the value as four lowercase hex digits plus a newline. A write to the string port makes the block walk a null-terminated string in memory through its own read master and emit each character plus a newline. The CPU stalls via `s_wait` while the block is busy.

---
 rtl/mmio_result_printer.sv | 191 +++++++++++++++++++
 tb/tb_mmio_result_printer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_result_printer.sv
// Result printer on the CPU data bus: turns integer writes into four hex digits and
// string-pointer writes into a memory walk, emitting each result as ASCII plus EOL.
`timescale 1ns/1ps
module mmio_result_printer #(
  parameter logic [15:0] INT_ADDR  = 16'h1000,
  parameter logic [15:0] STR_ADDR  = 16'h1002,
  parameter logic [15:0] STAT_ADDR = 16'h1004,
  parameter int          MAX_LEN   = 512,
  parameter logic [7:0]  EOL       = 8'h0A
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] s_addr,
  input  logic        s_wr,
  input  logic [15:0] s_wrdata,
  input  logic        s_rd,
  output logic [15:0] s_rddata,
  output logic        s_rddatavalid,
  output logic        s_wait,
  output logic [15:0] m_addr,
  output logic        m_rd,
  input  logic [15:0] m_rddata,
  input  logic        m_rddatavalid,
  input  logic        m_wait,
  output logic [7:0]  o_char,
  output logic        o_char_valid,
  input  logic        i_char_ready,
  output logic        o_done
);

  typedef enum logic [2:0] {IDLE, HEX, FETCH, WAITD, EMIT, EOLS} state_t;

  localparam logic [9:0] MAX_LEN_C = MAX_LEN[9:0];

  state_t      state_q, state_d;
  logic [15:0] val_q, val_d;
  logic [1:0]  dig_q, dig_d;
  logic [15:0] ptr_q, ptr_d;
  logic [9:0]  len_q, len_d;
  logic [9:0]  last_len_q, last_len_d;
  logic        ovf_q, ovf_d;
  logic [7:0]  char_q, char_d;
  logic        cvld_q, cvld_d;
  logic [15:0] rddata_q, rddata_d;
  logic        rdvld_q, rdvld_d;

  logic        wr_int, wr_str, accept;
  logic [1:0]  dig_nxt;
  logic [9:0]  len_inc;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Digit 0 is the most significant nibble.
  function automatic logic [3:0] nibble(input logic [15:0] v, input logic [1:0] k);
    case (k)
      2'd0:    return v[15:12];
      2'd1:    return v[11:8];
      2'd2:    return v[7:4];
      default: return v[3:0];
    endcase
  endfunction

  assign wr_int  = s_wr && (s_addr == INT_ADDR);
  assign wr_str  = s_wr && (s_addr == STR_ADDR);
  assign accept  = cvld_q && i_char_ready;
  assign dig_nxt = dig_q + 2'd1;
  assign len_inc = len_q + 10'd1;

  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    dig_d      = dig_q;
    ptr_d      = ptr_q;
    len_d      = len_q;
    last_len_d = last_len_q;
    ovf_d      = ovf_q;
    char_d     = char_q;
    cvld_d     = cvld_q;
    case (state_q)
      IDLE: begin
        if (wr_int) begin
          val_d   = s_wrdata;
          dig_d   = 2'd0;
          char_d  = hex_char(s_wrdata[15:12]);
          cvld_d  = 1'b1;
          state_d = HEX;
        end else if (wr_str) begin
          ptr_d   = {s_wrdata[15:1], 1'b0};
          len_d   = 10'd0;
          ovf_d   = 1'b0;
          state_d = FETCH;
        end
      end
      HEX: begin
        if (accept) begin
          if (dig_q == 2'd3) begin
            char_d  = EOL;
            state_d = EOLS;
          end else begin
            dig_d  = dig_nxt;
            char_d = hex_char(nibble(val_q, dig_nxt));
          end
        end
      end
      FETCH: begin
        if (!m_wait) state_d = WAITD;
      end
      WAITD: begin
        if (m_rddatavalid) begin
          cvld_d = 1'b1;
          if (m_rddata == 16'h0000) begin
            char_d  = EOL;
            state_d = EOLS;
          end else begin
            char_d  = m_rddata[7:0];
            state_d = EMIT;
          end
        end
      end
      EMIT: begin
        if (accept) begin
          ptr_d = ptr_q + 16'd2;
          len_d = len_inc;
          if (len_inc == MAX_LEN_C) begin
            ovf_d   = 1'b1;
            char_d  = EOL;
            state_d = EOLS;
          end else begin
            cvld_d  = 1'b0;
            state_d = FETCH;
          end
        end
      end
      EOLS: begin
        if (accept) begin
          cvld_d     = 1'b0;
          last_len_d = len_q;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdvld_d  = s_rd && (s_addr == STAT_ADDR);
    rddata_d = 16'h0000;
    if (rdvld_d) rddata_d = {4'h0, last_len_q, ovf_q, state_q != IDLE};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      val_q      <= '0;
      dig_q      <= '0;
      ptr_q      <= '0;
      len_q      <= '0;
      last_len_q <= '0;
      ovf_q      <= 1'b0;
      char_q     <= '0;
      cvld_q     <= 1'b0;
      rddata_q   <= '0;
      rdvld_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      dig_q      <= dig_d;
      ptr_q      <= ptr_d;
      len_q      <= len_d;
      last_len_q <= last_len_d;
      ovf_q      <= ovf_d;
      char_q     <= char_d;
      cvld_q     <= cvld_d;
      rddata_q   <= rddata_d;
      rdvld_q    <= rdvld_d;
    end
  end

  // The state is registered, so a write in the cycle the FSM leaves EOLS still stalls.
  assign s_wait        = (wr_int || wr_str) && (state_q != IDLE);
  assign s_rddata      = rddata_q;
  assign s_rddatavalid = rdvld_q;
  assign m_addr        = ptr_q;
  assign m_rd          = (state_q == FETCH);
  assign o_char        = char_q;
  assign o_char_valid  = cvld_q;
  assign o_done        = accept && (state_q == EOLS);

endmodule

// File: tb/tb_mmio_result_printer.sv
// Directed bench for mmio_result_printer: table of integer writes plus string,
// back-pressure, overflow, stall and reset sequences against a 1-cycle memory model.
`timescale 1ns/1ps
module tb_mmio_result_printer;

  localparam logic [15:0] INT_A  = 16'h1000;
  localparam logic [15:0] STR_A  = 16'h1002;
  localparam logic [15:0] STAT_A = 16'h1004;

  logic        clk, reset_n;
  logic [15:0] s_addr, s_wrdata, s_rddata, m_addr, m_rddata;
  logic        s_wr, s_rd, s_rddatavalid, s_wait, m_rd, m_rddatavalid, m_wait;
  logic [7:0]  o_char;
  logic        o_char_valid, i_char_ready, o_done;

  mmio_result_printer dut (
    .clk(clk), .reset_n(reset_n),
    .s_addr(s_addr), .s_wr(s_wr), .s_wrdata(s_wrdata), .s_rd(s_rd),
    .s_rddata(s_rddata), .s_rddatavalid(s_rddatavalid), .s_wait(s_wait),
    .m_addr(m_addr), .m_rd(m_rd), .m_rddata(m_rddata),
    .m_rddatavalid(m_rddatavalid), .m_wait(m_wait),
    .o_char(o_char), .o_char_valid(o_char_valid), .i_char_ready(i_char_ready),
    .o_done(o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] mem [0:32767];
  logic        mem_inj;

  always @(posedge clk) begin
    if (mem_inj) begin
      m_rddatavalid <= 1'b1;
      m_rddata      <= 16'h0055;
    end else if (m_rd && !m_wait) begin
      m_rddatavalid <= 1'b1;
      m_rddata      <= mem[m_addr[15:1]];
    end else begin
      m_rddatavalid <= 1'b0;
    end
  end

  logic [7:0]  chars[$];
  int          stamps[$];
  logic [15:0] addrs[$];
  int          done_cnt;

  always @(negedge clk) begin
    if (o_char_valid && i_char_ready) begin
      chars.push_back(o_char);
      stamps.push_back(cyc);
    end
    if (o_done) done_cnt++;
    if (m_rd && !m_wait) addrs.push_back(m_addr);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] cget(input int k);
    return (k < chars.size()) ? chars[k] : 8'hEE;
  endfunction

  function automatic int sget(input int k);
    return (k < stamps.size()) ? stamps[k] : -1;
  endfunction

  function automatic logic [15:0] aget(input int k);
    return (k < addrs.size()) ? addrs[k] : 16'hDEAD;
  endfunction

  task automatic clear_logs();
    chars.delete();
    stamps.delete();
    addrs.delete();
    done_cnt = 0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d,
                           output int acc, output int stalls);
    int guard;
    stalls = 0;
    guard  = 0;
    @(posedge clk); #1;
    s_addr = a; s_wr = 1'b1; s_wrdata = d;
    #1;
    while (s_wait && guard < 5000) begin
      stalls++;
      guard++;
      @(posedge clk); #2;
    end
    if (s_wait) chk("write_timeout", 32'(s_wait), 32'd0);
    acc = cyc;
    @(posedge clk); #1;
    s_wr = 1'b0; s_addr = 16'h0; s_wrdata = 16'h0;
  endtask

  task automatic stat_read(input logic [15:0] exp, input string nm);
    @(posedge clk); #1;
    s_rd = 1'b1; s_addr = STAT_A;
    @(posedge clk); #1;
    s_rd = 1'b0; s_addr = 16'h0;
    chk({nm, "_valid"}, 32'(s_rddatavalid), 32'd1);
    chk(nm, 32'(s_rddata), 32'(exp));
    @(posedge clk); #1;
    chk({nm, "_valid_drop"}, 32'(s_rddatavalid), 32'd0);
  endtask

  task automatic wait_done(input int n, input int budget, input string nm);
    int k = 0;
    while (done_cnt < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk(nm, 32'(done_cnt), 32'(n));
  endtask

  task automatic check_reset_outs(input string nm);
    chk({nm, "_s_wait"}, 32'(s_wait), 0);
    chk({nm, "_rdvalid"}, 32'(s_rddatavalid), 0);
    chk({nm, "_rddata"}, 32'(s_rddata), 0);
    chk({nm, "_m_rd"}, 32'(m_rd), 0);
    chk({nm, "_m_addr"}, 32'(m_addr), 0);
    chk({nm, "_char"}, 32'(o_char), 0);
    chk({nm, "_char_valid"}, 32'(o_char_valid), 0);
    chk({nm, "_done"}, 32'(o_done), 0);
  endtask

  typedef struct {
    logic [15:0] val;
    logic [39:0] exp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int acc, stalls, bad, seen;
    logic [39:0] e;

    vecs[0] = '{16'h3fA0, 40'h33_66_61_30_0A};
    vecs[1] = '{16'h0000, 40'h30_30_30_30_0A};
    vecs[2] = '{16'hFFFF, 40'h66_66_66_66_0A};
    vecs[3] = '{16'h1234, 40'h31_32_33_34_0A};
    vecs[4] = '{16'h9abc, 40'h39_61_62_63_0A};
    vecs[5] = '{16'h5e07, 40'h35_65_30_37_0A};

    for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
    mem[16'h1000] = 16'h0048;
    mem[16'h1001] = 16'h0069;
    mem[16'h1002] = 16'h0000;
    for (int i = 0; i < 600; i++) mem[16'h1800 + i] = {8'h01, 8'h41 + 8'(i % 26)};

    reset_n = 1'b0; s_addr = 0; s_wr = 0; s_wrdata = 0; s_rd = 0;
    m_wait = 0; i_char_ready = 1; mem_inj = 0;
    clear_logs();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outs("reset");
    reset_n = 1'b1;
    stat_read(16'h0000, "stat_after_reset");

    // Integer writes from the vector table.
    for (int i = 0; i < 6; i++) begin
      clear_logs();
      e = vecs[i].exp;
      bus_write(INT_A, vecs[i].val, acc, stalls);
      wait_done(1, 50, $sformatf("int%0d_done", i));
      chk($sformatf("int%0d_no_stall", i), 32'(stalls), 0);
      chk($sformatf("int%0d_count", i), 32'(chars.size()), 5);
      for (int k = 0; k < 5; k++)
        chk($sformatf("int%0d_char%0d", i, k), 32'(cget(k)), 32'(e[39-8*k -: 8]));
      chk($sformatf("int%0d_first_cycle", i), 32'(sget(0)), 32'(acc + 1));
      chk($sformatf("int%0d_last_cycle", i), 32'(sget(4)), 32'(acc + 5));
    end

    // String "Hi" at 0x2000, odd pointer forced even.
    clear_logs();
    bus_write(STR_A, 16'h2001, acc, stalls);
    wait_done(1, 100, "str_done");
    chk("str_count", 32'(chars.size()), 3);
    chk("str_c0", 32'(cget(0)), 32'h48);
    chk("str_c1", 32'(cget(1)), 32'h69);
    chk("str_c2", 32'(cget(2)), 32'h0A);
    chk("str_a0", 32'(aget(0)), 32'h2000);
    chk("str_a1", 32'(aget(1)), 32'h2002);
    chk("str_a2", 32'(aget(2)), 32'h2004);
    chk("str_h_cycle", 32'(sget(0)), 32'(acc + 3));
    chk("str_eol_cycle", 32'(sget(2)), 32'(acc + 9));
    stat_read(16'h0008, "str_status");

    // Same string with fetch stall and output back-pressure.
    clear_logs();
    m_wait = 1'b1;
    bus_write(STR_A, 16'h2000, acc, stalls);
    chk("mw_rd0", 32'(m_rd), 1);
    chk("mw_addr0", 32'(m_addr), 32'h2000);
    @(posedge clk); #1;
    chk("mw_rd1", 32'(m_rd), 1);
    chk("mw_addr1", 32'(m_addr), 32'h2000);
    @(posedge clk); #1;
    chk("mw_rd2", 32'(m_rd), 1);
    chk("mw_addr2", 32'(m_addr), 32'h2000);
    m_wait = 1'b0;
    seen = 0;
    while (!(o_char_valid && o_char == 8'h69) && seen < 50) begin
      @(posedge clk); #1;
      seen++;
    end
    chk("bp_i_seen", 32'(o_char_valid && o_char == 8'h69), 1);
    i_char_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d_char", k), 32'(o_char), 32'h69);
      chk($sformatf("bp_hold%0d_valid", k), 32'(o_char_valid), 1);
    end
    i_char_ready = 1'b1;
    wait_done(1, 100, "bp_done");
    chk("bp_count", 32'(chars.size()), 3);
    chk("bp_c0", 32'(cget(0)), 32'h48);
    chk("bp_c1", 32'(cget(1)), 32'h69);
    chk("bp_c2", 32'(cget(2)), 32'h0A);
    chk("bp_addrs", 32'(addrs.size()), 3);
    chk("bp_a2", 32'(aget(2)), 32'h2004);

    // Unterminated string: truncated at 512 characters.
    clear_logs();
    bus_write(STR_A, 16'h3000, acc, stalls);
    wait_done(1, 3000, "long_done");
    chk("long_count", 32'(chars.size()), 513);
    bad = 0;
    for (int k = 0; k < 512; k++)
      if (cget(k) !== 8'h41 + 8'(k % 26)) bad++;
    chk("long_chars_bad", 32'(bad), 0);
    chk("long_eol", 32'(cget(512)), 32'h0A);
    chk("long_fetches", 32'(addrs.size()), 512);
    chk("long_last_addr", 32'(aget(511)), 32'h33FE);
    stat_read(16'h0802, "long_status");
    clear_logs();
    bus_write(STR_A, 16'h2000, acc, stalls);
    wait_done(1, 100, "ovf_clear_done");
    stat_read(16'h0008, "ovf_cleared_status");

    // Integer write stalled behind a string in progress.
    clear_logs();
    bus_write(STR_A, 16'h2000, acc, stalls);
    @(posedge clk); #1;
    s_rd = 1'b1; s_addr = STAT_A;
    @(posedge clk); #1;
    s_rd = 1'b0;
    chk("busy_status", 32'(s_rddata), 32'h0009);
    bus_write(INT_A, 16'h00ff, acc, stalls);
    wait_done(2, 100, "stall_done");
    chk("stall_seen", 32'(stalls > 0), 1);
    chk("stall_count", 32'(chars.size()), 8);
    chk("stall_c2", 32'(cget(2)), 32'h0A);
    chk("stall_c3", 32'(cget(3)), 32'h30);
    chk("stall_c5", 32'(cget(5)), 32'h66);
    chk("stall_c7", 32'(cget(7)), 32'h0A);
    chk("stall_accept_cycle", 32'(acc), 32'(sget(2) + 1));
    chk("stall_first_digit", 32'(sget(3)), 32'(sget(2) + 2));

    // Reset during WAITD, stale response afterwards.
    clear_logs();
    bus_write(STR_A, 16'h2000, acc, stalls);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_reset_outs("midreset");
    clear_logs();
    repeat (2) @(posedge clk);
    #1;
    mem_inj = 1'b1;
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    mem_inj = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("stale_no_char", 32'(chars.size()), 0);
    chk("stale_no_done", 32'(done_cnt), 0);
    chk("stale_char_valid", 32'(o_char_valid), 0);
    stat_read(16'h0000, "post_reset_status");
    clear_logs();
    bus_write(INT_A, 16'hbeef, acc, stalls);
    wait_done(1, 50, "post_reset_done");
    chk("post_reset_count", 32'(chars.size()), 5);
    chk("post_reset_c0", 32'(cget(0)), 32'h62);
    chk("post_reset_c3", 32'(cget(3)), 32'h66);
    chk("post_reset_c4", 32'(cget(4)), 32'h0A);
    chk("post_reset_first", 32'(sget(0)), 32'(acc + 1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
